sram_port_arbiter: RTL and testbench

//   Shares one 32-bit asynchronous SRAM bank between two requesters: port 0 (CPU bus) and port 1
//   (serial loader / ram_driver path). Round-robin arbitration with fixed-latency access sequencing.

---
 rtl/sram_port_arbiter_if.sv | 39 +++
 rtl/sram_port_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter_if
//   One requester port of the SRAM arbiter. A requester raises req with
//   we/addr/wdata/be stable and holds them until ack pulses for one cycle.
//   rdata carries read data while ack is high and keeps it until the next
//   read on the same port completes.
//
//   Signals
//     req    requester -> arbiter  transaction request
//     we     requester -> arbiter  1 = write, 0 = read
//     addr   requester -> arbiter  SRAM word address
//     wdata  requester -> arbiter  write data
//     be     requester -> arbiter  byte enables, active high (bit0 = [7:0])
//     ack    arbiter -> requester  one-cycle completion pulse
//     rdata  arbiter -> requester  read data
//
//   Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 20
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        be;
  logic              ack;
  logic [31:0]       rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ack, rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//   Shares one 32-bit asynchronous SRAM bank between two requesters
//   (p0 = CPU bus, p1 = serial loader). Round-robin arbitration, one
//   transaction in flight, fixed sequence IDLE -> SETUP -> ACCESS
//   (WAIT_CYCLES) -> HOLD -> DONE -> IDLE. Every output is a flop.
//
//   Parameters
//     ADDR_W       SRAM word-address width
//     WAIT_CYCLES  strobe low time in ACCESS, 1..15
//
//   Ports
//     clk, rst       clock, synchronous active-low reset
//     p0, p1         requester ports (slave side of sram_port_arbiter_if)
//     grant          one-hot owner of the current transaction, 0 when idle
//     sram_addr      SRAM address
//     sram_dout      data towards the pad
//     sram_dout_en   pad output enable
//     sram_din       data from the pad
//     sram_ce_n, sram_oe_n, sram_we_n   SRAM strobes, active low
//     sram_be_n      SRAM byte lanes, active low
// ---------------------------------------------------------------------------
module sram_port_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  sram_port_arbiter_if.slave p0,
  sram_port_arbiter_if.slave p1,
  output logic [1:0]        grant,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_dout,
  output logic              sram_dout_en,
  input  logic [31:0]       sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // ACCESS counts down from WAIT_CYCLES-1 to 0, so it lasts WAIT_CYCLES cycles.
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;  // index of the most recent winner
  logic              owner_q, owner_d;            // index of the current owner
  logic              txn_we_q, txn_we_d;
  logic [1:0]        grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       dout_q, dout_d;
  logic              dout_en_q, dout_en_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic [3:0]        be_n_q, be_n_d;
  logic [1:0]        ack_q, ack_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic [31:0]       rdata1_q, rdata1_d;

  logic              pick;      // winning port index when in IDLE
  logic              pick_we;
  logic [ADDR_W-1:0] pick_addr;
  logic [31:0]       pick_wdata;
  logic [3:0]        pick_be;

  always_comb begin
    // On a tie the port that did not win last time goes next.
    pick = 1'b0;
    if (p0.req && p1.req) begin
      pick = ~last_grant_q;
    end else if (p1.req) begin
      pick = 1'b1;
    end
    pick_we    = pick ? p1.we    : p0.we;
    pick_addr  = pick ? p1.addr  : p0.addr;
    pick_wdata = pick ? p1.wdata : p0.wdata;
    pick_be    = pick ? p1.be    : p0.be;

    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    txn_we_d     = txn_we_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    dout_d       = dout_q;
    dout_en_d    = dout_en_q;
    ce_n_d       = ce_n_q;
    oe_n_d       = oe_n_q;
    we_n_d       = we_n_q;
    be_n_d       = be_n_q;
    ack_d        = 2'b00;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    case (state_q)
      IDLE: begin
        if (p0.req || p1.req) begin
          // Outputs for SETUP are loaded here so they appear in SETUP.
          owner_d      = pick;
          last_grant_d = pick;
          grant_d      = pick ? 2'b10 : 2'b01;
          txn_we_d     = pick_we;
          addr_d       = pick_addr;
          be_n_d       = ~pick_be;
          ce_n_d       = 1'b0;
          if (pick_we) begin
            dout_d    = pick_wdata;
            dout_en_d = 1'b1;
          end else begin
            oe_n_d = 1'b0;
          end
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d = CNT_INIT;
        if (txn_we_q) begin
          we_n_d = 1'b0;
        end
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          // Last strobe-low cycle: capture read data before oe_n rises.
          we_n_d = 1'b1;
          oe_n_d = 1'b1;
          if (!txn_we_q) begin
            if (owner_q) begin
              rdata1_d = sram_din;
            end else begin
              rdata0_d = sram_din;
            end
          end
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        // ce_n, addr and the write data were held through HOLD; release now.
        ce_n_d    = 1'b1;
        dout_en_d = 1'b0;
        be_n_d    = 4'hF;
        ack_d     = owner_q ? 2'b10 : 2'b01;
        state_d   = DONE;
      end
      DONE: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      txn_we_q     <= 1'b0;
      grant_q      <= 2'b00;
      addr_q       <= '0;
      dout_q       <= 32'h0;
      dout_en_q    <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      be_n_q       <= 4'hF;
      ack_q        <= 2'b00;
      rdata0_q     <= 32'h0;
      rdata1_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      txn_we_q     <= txn_we_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
      dout_en_q    <= dout_en_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      be_n_q       <= be_n_d;
      ack_q        <= ack_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign p0.ack       = ack_q[0];
  assign p1.ack       = ack_q[1];
  assign p0.rdata     = rdata0_q;
  assign p1.rdata     = rdata1_q;
  assign grant        = grant_q;
  assign sram_addr    = addr_q;
  assign sram_dout    = dout_q;
  assign sram_dout_en = dout_en_q;
  assign sram_ce_n    = ce_n_q;
  assign sram_oe_n    = oe_n_q;
  assign sram_we_n    = we_n_q;
  assign sram_be_n    = be_n_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;
  localparam int AW     = 20;
  localparam int W      = 2;
  localparam int LAT    = 3 + W;
  localparam int PERIOD = 4 + W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_W(AW)) if0 ();
  sram_port_arbiter_if #(.ADDR_W(AW)) if1 ();

  logic [1:0]    grant;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_dout;
  logic          sram_dout_en;
  logic [31:0]   sram_din;
  logic          sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]    sram_be_n;

  sram_port_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .p0(if0), .p1(if1), .grant(grant),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_dout_en(sram_dout_en),
    .sram_din(sram_din), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int strobe_viol = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Asynchronous SRAM model (512 words); undriven bus reads a marker value.
  logic [31:0] sram_mem [0:511];
  assign sram_din = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[8:0]] : 32'hBAD0_BAD0;
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) sram_mem[sram_addr[8:0]][b*8 +: 8] <= sram_dout[b*8 +: 8];
    end
  end

  // Strobe rules watched on every cycle out of reset.
  always @(negedge clk) begin
    if (rst) begin
      if (!sram_we_n && !sram_oe_n) strobe_viol++;
      if (sram_dout_en && !sram_oe_n) strobe_viol++;
    end
  end

  // Reference model: expected memory contents and last arbitration winner.
  logic [31:0] ref_mem [0:511];
  bit model_last = 1'b1;

  function automatic void ref_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    ref_mem[a[8:0]] = (ref_mem[a[8:0]] & ~mask) | (d & mask);
  endfunction

  // Runs one transaction on one port from an IDLE cycle (called at posedge+1)
  // and returns what it observed; the calling test compares.
  task automatic do_txn(input bit port, input bit we, input logic [AW-1:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        output int lat, output int we_low, output int oe_low,
                        output int bad_side, output logic [31:0] rd, output int ack_cyc,
                        output logic [3:0] be_seen, output logic [AW-1:0] addr_seen,
                        output logic [31:0] dout_seen);
    logic [31:0] other_before, own_before;
    bit got_ack;
    lat = 0; we_low = 0; oe_low = 0; bad_side = 0; rd = '0; ack_cyc = -1; got_ack = 0;
    be_seen = 'x; addr_seen = 'x; dout_seen = 'x;
    other_before = port ? if0.rdata : if1.rdata;
    own_before   = port ? if1.rdata : if0.rdata;
    if (!port) begin
      if0.req = 1'b1; if0.we = we; if0.addr = addr; if0.wdata = wd; if0.be = be;
    end else begin
      if1.req = 1'b1; if1.we = we; if1.addr = addr; if1.wdata = wd; if1.be = be;
    end
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        be_seen = sram_be_n; addr_seen = sram_addr; dout_seen = sram_dout;
      end
      if (!sram_we_n) we_low++;
      if (!sram_oe_n) oe_low++;
      if ((port ? if0.ack : if1.ack) !== 1'b0) bad_side++;
      if (grant !== (port ? 2'b10 : 2'b01)) bad_side++;
      if ((port ? if1.ack : if0.ack) === 1'b1) begin
        rd = port ? if1.rdata : if0.rdata;
        ack_cyc = cyc;
        got_ack = 1;
        break;
      end
    end
    if ((port ? if0.rdata : if1.rdata) !== other_before) bad_side++;
    if (we && ((port ? if1.rdata : if0.rdata) !== own_before)) bad_side++;
    @(posedge clk); #1;
    if ((port ? if1.ack : if0.ack) !== 1'b0) bad_side++;
    if (grant !== 2'b00) bad_side++;
    if0.req = 1'b0; if1.req = 1'b0;
    if (got_ack) begin
      if (we) ref_write(addr, wd, be);
      model_last = port;
    end
    $display("txn port=%0d we=%0d addr=%05h wdata=%08h be=%h lat=%0d rdata=%08h",
             port, we, addr, wd, be, lat, rd);
  endtask

  task automatic test_reset();
    if0.req = 0; if0.we = 0; if0.addr = '0; if0.wdata = '0; if0.be = '0;
    if1.req = 0; if1.we = 0; if1.addr = '0; if1.wdata = '0; if1.be = '0;
    for (int i = 0; i < 512; i++) begin sram_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 111", {sram_ce_n, sram_oe_n, sram_we_n});
    end
    n_checks++;
    if (sram_be_n !== 4'hF || sram_dout_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_be_den: got be_n=%h den=%b expected F 0", sram_be_n, sram_dout_en);
    end
    n_checks++;
    if (sram_addr !== '0 || sram_dout !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus: got addr=%h dout=%h expected 0 0", sram_addr, sram_dout);
    end
    n_checks++;
    if ({if0.ack, if1.ack, grant} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ack_grant: got %b expected 0000", {if0.ack, if1.ack, grant});
    end
    n_checks++;
    if (if0.rdata !== 32'h0 || if1.rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h %h expected 0 0", if0.rdata, if1.rdata);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_last = 1'b1;
  endtask

  task automatic test_write_p0();
    int lat, wl, ol, bs, ac; logic [31:0] rd, ds; logic [3:0] bes; logic [AW-1:0] as;
    do_txn(1'b0, 1'b1, 20'h00010, 32'hDEADBEEF, 4'hF, lat, wl, ol, bs, rd, ac, bes, as, ds);
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL write_latency: got %0d expected %0d", lat, LAT); end
    n_checks++;
    if (wl !== W || ol !== 0) begin n_fail++; $display("FAIL write_strobes: got we_low=%0d oe_low=%0d expected %0d 0", wl, ol, W); end
    n_checks++;
    if (bes !== 4'h0 || as !== 20'h00010 || ds !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL write_setup: got be_n=%h addr=%h dout=%h expected 0 00010 deadbeef", bes, as, ds);
    end
    n_checks++;
    if (bs !== 0) begin n_fail++; $display("FAIL write_side: got %0d side errors expected 0", bs); end
  endtask

  task automatic test_read_p1();
    int lat, wl, ol, bs, ac; logic [31:0] rd, ds; logic [3:0] bes; logic [AW-1:0] as;
    do_txn(1'b1, 1'b0, 20'h00010, 32'h0, 4'hF, lat, wl, ol, bs, rd, ac, bes, as, ds);
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data: got %h expected deadbeef", rd); end
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL read_latency: got %0d expected %0d", lat, LAT); end
    n_checks++;
    if (ol !== W + 1 || wl !== 0) begin n_fail++; $display("FAIL read_strobes: got oe_low=%0d we_low=%0d expected %0d 0", ol, wl, W + 1); end
    n_checks++;
    if (bs !== 0) begin n_fail++; $display("FAIL read_side: got %0d side errors expected 0", bs); end
  endtask

  task automatic test_tie();
    bit exp, got;
    int nack = 0, prev = -1, n0 = 0, n1 = 0;
    exp = ~model_last;
    if0.req = 1; if0.we = 1; if0.addr = 20'h00020; if0.wdata = $urandom; if0.be = 4'hF;
    if1.req = 1; if1.we = 0; if1.addr = 20'h00010; if1.wdata = '0;      if1.be = 4'hF;
    for (int c = 0; c < 60 && nack < 4; c++) begin
      @(negedge clk);
      if (if0.ack === 1'b1 && if1.ack === 1'b1) begin
        n_checks++; n_fail++; $display("FAIL tie_double_ack: got both acks expected one");
      end else if (if0.ack === 1'b1 || if1.ack === 1'b1) begin
        got = if1.ack;
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL tie_order: got port %0d expected port %0d", got, exp); end
        if (prev >= 0) begin
          n_checks++;
          if (cyc - prev !== PERIOD) begin n_fail++; $display("FAIL tie_period: got %0d expected %0d", cyc - prev, PERIOD); end
        end
        if (got) begin
          n1++;
          n_checks++;
          if (if1.rdata !== ref_mem[9'h010]) begin n_fail++; $display("FAIL tie_rdata: got %h expected %h", if1.rdata, ref_mem[9'h010]); end
        end else begin
          n0++;
          ref_write(if0.addr, if0.wdata, if0.be);
        end
        model_last = got; exp = ~got; prev = cyc; nack++;
        @(posedge clk); #1;
        if (nack == 4) begin
          if0.req = 0; if1.req = 0;
        end else if (!got) begin
          if0.addr = if0.addr + 20'd1; if0.wdata = $urandom;
        end
      end
    end
    n_checks++;
    if (n0 !== 2 || n1 !== 2) begin n_fail++; $display("FAIL tie_counts: got p0=%0d p1=%0d expected 2 2", n0, n1); end
    if (nack < 4) begin
      @(posedge clk); #1; if0.req = 0; if1.req = 0;
      repeat (2 * PERIOD) @(posedge clk); #1;
    end
  endtask

  task automatic test_byte_lanes();
    int lat, wl, ol, bs, ac; logic [31:0] rd, ds; logic [3:0] bes; logic [AW-1:0] as;
    do_txn(1'b0, 1'b1, 20'h00030, 32'hFFFFFFFF, 4'hF, lat, wl, ol, bs, rd, ac, bes, as, ds);
    do_txn(1'b0, 1'b1, 20'h00030, 32'h11223344, 4'b0101, lat, wl, ol, bs, rd, ac, bes, as, ds);
    n_checks++;
    if (bes !== 4'b1010) begin n_fail++; $display("FAIL lanes_be_n: got %b expected 1010", bes); end
    do_txn(1'b0, 1'b0, 20'h00030, 32'h0, 4'hF, lat, wl, ol, bs, rd, ac, bes, as, ds);
    n_checks++;
    if (rd !== 32'hFF22FF44) begin n_fail++; $display("FAIL lanes_merge: got %h expected ff22ff44", rd); end
    do_txn(1'b0, 1'b1, 20'h00030, 32'h0, 4'h0, lat, wl, ol, bs, rd, ac, bes, as, ds);
    n_checks++;
    if (lat !== LAT || wl !== W || bes !== 4'hF) begin
      n_fail++; $display("FAIL lanes_be0: got lat=%0d we_low=%0d be_n=%h expected %0d %0d F", lat, wl, bes, LAT, W);
    end
    do_txn(1'b1, 1'b0, 20'h00030, 32'h0, 4'hF, lat, wl, ol, bs, rd, ac, bes, as, ds);
    n_checks++;
    if (rd !== 32'hFF22FF44) begin n_fail++; $display("FAIL lanes_be0_data: got %h expected ff22ff44", rd); end
  endtask

  task automatic test_reset_abort();
    int acks = 0;
    if1.req = 1; if1.we = 1; if1.addr = 20'h001F0; if1.wdata = 32'hCAFEF00D; if1.be = 4'hF;
    @(posedge clk); @(posedge clk); #1;   // now in the first ACCESS cycle
    rst = 1'b0; if1.req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en} !== 4'b1110) begin
      n_fail++; $display("FAIL abort_strobes: got %b expected 1110", {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en});
    end
    n_checks++;
    if (grant !== 2'b00) begin n_fail++; $display("FAIL abort_grant: got %b expected 00", grant); end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (if0.ack === 1'b1 || if1.ack === 1'b1) acks++;
    end
    n_checks++;
    if (acks !== 0) begin n_fail++; $display("FAIL abort_ack: got %0d acks expected 0", acks); end
    model_last = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat, wl, ol, bs, ac, prev; logic [31:0] rd, ds, wd, expd; logic [3:0] bes; logic [AW-1:0] as, a;
    bit we;
    prev = -1;
    for (int k = 0; k < 3; k++) begin
      we = (k != 1); a = 20'h00040 + 20'(k % 2); wd = $urandom;
      expd = ref_mem[a[8:0]];
      do_txn(1'b1, we, a, wd, 4'hF, lat, wl, ol, bs, rd, ac, bes, as, ds);
      n_checks++;
      if (lat !== LAT) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT); end
      if (!we) begin
        n_checks++;
        if (rd !== expd) begin n_fail++; $display("FAIL b2b_rdata: got %h expected %h", rd, expd); end
      end
      if (prev >= 0) begin
        n_checks++;
        if (ac - prev !== PERIOD) begin n_fail++; $display("FAIL b2b_period: got %0d expected %0d", ac - prev, PERIOD); end
      end
      prev = ac;
    end
  endtask

  task automatic test_random();
    int lat, wl, ol, bs, ac; logic [31:0] rd, ds, wd, expd; logic [3:0] bes, be; logic [AW-1:0] as, a;
    bit port, we;
    for (int k = 0; k < 40; k++) begin
      port = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
      a = 20'($urandom_range(0, 63)); wd = $urandom; be = 4'($urandom_range(0, 15));
      expd = ref_mem[a[8:0]];
      do_txn(port, we, a, wd, be, lat, wl, ol, bs, rd, ac, bes, as, ds);
      n_checks++;
      if (lat !== LAT) begin n_fail++; $display("FAIL rand_latency: got %0d expected %0d", lat, LAT); end
      n_checks++;
      if (we ? (wl !== W || ol !== 0) : (ol !== W + 1 || wl !== 0)) begin
        n_fail++; $display("FAIL rand_strobes: got we_low=%0d oe_low=%0d for we=%0d", wl, ol, we);
      end
      if (!we) begin
        n_checks++;
        if (rd !== expd) begin n_fail++; $display("FAIL rand_rdata: got %h expected %h addr %h", rd, expd, a); end
      end
      n_checks++;
      if (bs !== 0) begin n_fail++; $display("FAIL rand_side: got %0d side errors expected 0", bs); end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_strobe_rules();
    n_checks++;
    if (strobe_viol !== 0) begin n_fail++; $display("FAIL strobe_rules: got %0d violations expected 0", strobe_viol); end
  endtask

  initial begin
    test_reset();
    test_write_p0();
    test_read_p1();
    test_tie();
    test_byte_lanes();
    test_reset_abort();
    test_back_to_back();
    test_random();
    test_strobe_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
